// File: rtl/serial_port_bridge.sv
// serial_port_bridge: RX/TX byte FIFOs between the processor serial ports and a host link.
// Optional TX->RX loopback is built only when SERIAL_LOOPBACK_EN is defined.
module serial_port_bridge #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [7:0]            proc_rx_data,
   output logic                  proc_rx_valid,
   input  logic                  proc_rx_rden,
   output logic                  proc_tx_ready,
   input  logic [7:0]            proc_tx_data,
   input  logic                  proc_tx_wren,
   input  logic [7:0]            host_rx_data,
   input  logic                  host_rx_valid,
   output logic                  host_rx_ready,
   output logic [7:0]            host_tx_data,
   output logic                  host_tx_valid,
   input  logic                  host_tx_ready,
   input  logic                  loopback,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic                  rx_underflow,
   output logic                  tx_overflow
);
   localparam logic [DEPTH_LOG2:0] full_count = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
   logic [7:0] rx_mem [1 << DEPTH_LOG2];
   logic [7:0] tx_mem [1 << DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
   logic rx_full, tx_full, tx_nonempty, lb, lb_xfer;
   logic rx_push, rx_pop, tx_push, tx_pop;
   logic [7:0] rx_push_data;
`ifdef SERIAL_LOOPBACK_EN
   assign lb = loopback;
`else
   logic unused_loopback;
   assign unused_loopback = loopback;
   assign lb = 1'b0;
`endif
   assign rx_full       = rx_count == full_count;
   assign tx_full       = tx_count == full_count;
   assign tx_nonempty   = tx_count != '0;
   assign proc_rx_data  = rx_mem[rx_rp];
   assign host_tx_data  = tx_mem[tx_rp];
   assign proc_rx_valid = rx_count != '0;
   assign proc_tx_ready = !tx_full;
   // In loopback the host side is fenced off and the TX head feeds the RX FIFO directly.
   assign host_tx_valid = tx_nonempty && !lb;
   assign host_rx_ready = !rx_full && !lb;
   assign lb_xfer       = lb && tx_nonempty && !rx_full;
   assign rx_push       = lb ? lb_xfer : host_rx_valid && host_rx_ready;
   assign rx_push_data  = lb ? host_tx_data : host_rx_data;
   assign rx_pop        = proc_rx_rden && proc_rx_valid;
   assign tx_push       = proc_tx_wren && proc_tx_ready;
   assign tx_pop        = lb ? lb_xfer : host_tx_valid && host_tx_ready;
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_wp        <= '0;
         rx_rp        <= '0;
         tx_wp        <= '0;
         tx_rp        <= '0;
         rx_count     <= '0;
         tx_count     <= '0;
         rx_underflow <= 1'b0;
         tx_overflow  <= 1'b0;
      end else begin
         rx_wp        <= rx_wp + DEPTH_LOG2'(rx_push);
         rx_rp        <= rx_rp + DEPTH_LOG2'(rx_pop);
         tx_wp        <= tx_wp + DEPTH_LOG2'(tx_push);
         tx_rp        <= tx_rp + DEPTH_LOG2'(tx_pop);
         rx_count     <= rx_count + (DEPTH_LOG2+1)'(rx_push) - (DEPTH_LOG2+1)'(rx_pop);
         tx_count     <= tx_count + (DEPTH_LOG2+1)'(tx_push) - (DEPTH_LOG2+1)'(tx_pop);
         rx_underflow <= rx_underflow | (proc_rx_rden && !proc_rx_valid);
         tx_overflow  <= tx_overflow | (proc_tx_wren && tx_full);
      end
   end
   always_ff @(posedge clock) begin
      if (rx_push) rx_mem[rx_wp] <= rx_push_data;
      if (tx_push) tx_mem[tx_wp] <= proc_tx_data;
   end
endmodule

// File: tb/tb_serial_port_bridge.sv
// tb_serial_port_bridge: directed and random stimulus checked against a queue-based model.
module tb_serial_port_bridge;
   localparam int D = 8;
`ifdef SERIAL_LOOPBACK_EN
   localparam bit LB_ON = 1'b1;
`else
   localparam bit LB_ON = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b1;
   logic [7:0] host_rx_data = '0, proc_tx_data = '0;
   logic host_rx_valid = 0, host_tx_ready = 0, proc_rx_rden = 0, proc_tx_wren = 0, loopback = 0;
   logic [7:0] proc_rx_data, host_tx_data;
   logic proc_rx_valid, proc_tx_ready, host_rx_ready, host_tx_valid, rx_underflow, tx_overflow;
   logic [3:0] rx_count, tx_count;
   int tests = 0, fails = 0;
   logic [7:0] qrx[$], qtx[$];
   bit m_unf, m_ovf;

   serial_port_bridge #(.DEPTH_LOG2(3)) dut (
      .clock(clock), .reset(reset),
      .proc_rx_data(proc_rx_data), .proc_rx_valid(proc_rx_valid), .proc_rx_rden(proc_rx_rden),
      .proc_tx_ready(proc_tx_ready), .proc_tx_data(proc_tx_data), .proc_tx_wren(proc_tx_wren),
      .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
      .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
      .loopback(loopback), .rx_count(rx_count), .tx_count(tx_count),
      .rx_underflow(rx_underflow), .tx_overflow(tx_overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // One clock: decide transfers from the pre-edge model state, then compare after the edge.
   task automatic step();
      bit lbm, rxp, rxo, txp, txo;
      logic [7:0] rxd;
      lbm = loopback && LB_ON;
      rxp = 0; rxo = 0; txp = 0; txo = 0; rxd = '0;
      if (!reset) begin
         if (lbm) begin
            rxp = qtx.size() != 0 && qrx.size() != D;
            txo = rxp;
            if (rxp) rxd = qtx[0];
         end else begin
            rxp = host_rx_valid && qrx.size() != D;
            rxd = host_rx_data;
            txo = host_tx_ready && qtx.size() != 0;
         end
         rxo = proc_rx_rden && qrx.size() != 0;
         txp = proc_tx_wren && qtx.size() != D;
      end
      @(posedge clock);
      #1;
      if (reset) begin
         qrx.delete(); qtx.delete(); m_unf = 0; m_ovf = 0;
      end else begin
         if (proc_rx_rden && qrx.size() == 0) m_unf = 1;
         if (proc_tx_wren && qtx.size() == D) m_ovf = 1;
         if (rxo) void'(qrx.pop_front());
         if (txo) void'(qtx.pop_front());
         if (rxp) qrx.push_back(rxd);
         if (txp) qtx.push_back(proc_tx_data);
      end
      chk("rx_count", rx_count, qrx.size());
      chk("tx_count", tx_count, qtx.size());
      chk("proc_rx_valid", proc_rx_valid, qrx.size() != 0);
      chk("host_tx_valid", host_tx_valid, qtx.size() != 0 && !lbm);
      chk("proc_tx_ready", proc_tx_ready, qtx.size() != D);
      chk("host_rx_ready", host_rx_ready, qrx.size() != D && !lbm);
      chk("rx_underflow", rx_underflow, m_unf);
      chk("tx_overflow", tx_overflow, m_ovf);
      if (qrx.size() != 0) chk("proc_rx_data", proc_rx_data, qrx[0]);
      if (qtx.size() != 0) chk("host_tx_data", host_tx_data, qtx[0]);
   endtask

   task automatic idle();
      host_rx_valid = 0; host_tx_ready = 0; proc_rx_rden = 0; proc_tx_wren = 0;
   endtask

   initial begin
      reset = 1; step(); reset = 0; step();
      chk("reset_rx_count", rx_count, 0);
      chk("reset_ready", {proc_tx_ready, host_rx_ready, proc_rx_valid, host_tx_valid}, 4'b1100);
      // host bytes reach the processor in order
      for (int i = 0; i < 3; i++) begin host_rx_valid = 1; host_rx_data = 8'h41 + 8'(i); step(); end
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("rx_order", proc_rx_data, 8'h41 + 8'(i));
         proc_rx_rden = 1; step();
      end
      idle();
      chk("rx_drained_valid", proc_rx_valid, 0);
      // TX fills to 8, ninth byte dropped
      for (int i = 0; i < 9; i++) begin proc_tx_wren = 1; proc_tx_data = 8'(i); step(); end
      idle();
      chk("tx_full_ready", proc_tx_ready, 0);
      chk("tx_overflow_set", tx_overflow, 1);
      for (int i = 0; i < 8; i++) begin
         chk("tx_drain_order", host_tx_data, 8'(i));
         host_tx_ready = 1; step();
      end
      idle();
      chk("tx_drained_valid", host_tx_valid, 0);
      // steady push+pop across pointer wrap
      for (int i = 0; i < 4; i++) begin host_rx_valid = 1; host_rx_data = 8'h90 + 8'(i); step(); end
      for (int i = 0; i < 20; i++) begin
         host_rx_valid = 1; proc_rx_rden = 1; host_rx_data = 8'h10 + 8'(i); step();
         chk("rx_steady_count", rx_count, 4);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         chk("rx_wrap_order", proc_rx_data, 8'h10 + 8'(16 + i));
         proc_rx_rden = 1; step();
      end
      // underflow, then reset with data queued
      proc_rx_rden = 1; step(); idle();
      chk("rx_underflow_set", rx_underflow, 1);
      chk("rx_underflow_count", rx_count, 0);
      for (int i = 0; i < 5; i++) begin host_rx_valid = 1; proc_tx_wren = 1; host_rx_data = 8'(i); step(); end
      idle(); reset = 1; step(); reset = 0;
      chk("midreset_counts", {rx_count, tx_count}, 0);
      chk("midreset_flags", {rx_underflow, tx_overflow}, 0);
      if (LB_ON) begin
         loopback = 1;
         proc_tx_wren = 1; proc_tx_data = 8'h55; step(); idle(); step();
         chk("lb_first", proc_rx_data, 8'h55);
         proc_tx_wren = 1; proc_tx_data = 8'hAA; step(); idle(); host_tx_ready = 1; step();
         chk("lb_count", rx_count, 2);
         chk("lb_host_valid", host_tx_valid, 0);
         proc_rx_rden = 1; step();
         chk("lb_second", proc_rx_data, 8'hAA);
         idle(); loopback = 0;
      end
      // random traffic, fill-biased then drain-biased
      for (int i = 0; i < 600; i++) begin
         host_rx_valid = $urandom_range(0, 3) != 0;
         host_rx_data  = 8'($urandom);
         proc_tx_data  = 8'($urandom);
         proc_tx_wren  = $urandom_range(0, 3) != 0;
         proc_rx_rden  = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         host_tx_ready = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         loopback      = LB_ON && $urandom_range(0, 3) == 0;
         reset         = $urandom_range(0, 149) == 0;
         step();
      end
      reset = 0; idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
